// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the fetch/data RAM arbiter.
// Read-return ownership tags and byte-to-word address conversion.
package mem_arb_pkg;

  localparam int DEFAULT_ADDR_W    = 12;
  localparam int DEFAULT_DATA_W    = 64;
  localparam int DEFAULT_MAX_D_RUN = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } rd_owner_t;

  // Low byte-offset bits are simply dropped; misaligned addresses are not an error.
  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr,
                                            input int unsigned offset_bits);
    return byte_addr >> offset_bits;
  endfunction

endpackage

// File: rtl/arb_run_counter.sv
// Saturating counter of consecutive data-port grants while fetch is waiting.
// Raises at_limit once the streak reaches MAX_RUN so fetch can be forced through.
module arb_run_counter #(
  parameter int MAX_RUN = 4,
  localparam int CNT_W  = (MAX_RUN < 1) ? 1 : $clog2(MAX_RUN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic             at_limit,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             limit_hit;

  always_comb begin
    limit_hit = (count_q == CNT_W'(MAX_RUN));
    count_d   = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && !limit_hit) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_limit = limit_hit;
  assign count    = count_q;

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch (I) and memory stage (D).
// D has priority, bounded by a streak limit so fetch always makes progress; reads return after 1 cycle.
module imem_dmem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int MAX_D_RUN = DEFAULT_MAX_D_RUN,
  localparam int OFF_W    = $clog2(DATA_W / 8),
  localparam int MEM_AW   = ADDR_W - OFF_W
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_stall,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_stall,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,

  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int RUN_W = (MAX_D_RUN < 1) ? 1 : $clog2(MAX_D_RUN + 1);

  rd_owner_t         rd_owner_q, rd_owner_d;
  logic [DATA_W-1:0] i_hold_q, i_hold_d;
  logic [DATA_W-1:0] d_hold_q, d_hold_d;

  logic              i_req_v;
  logic              d_req_v;
  logic              run_at_limit;
  logic              run_clear;
  logic              run_inc;
  logic [RUN_W-1:0]  d_run;

  arb_run_counter #(
    .MAX_RUN (MAX_D_RUN)
  ) u_run_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (run_clear),
    .inc      (run_inc),
    .at_limit (run_at_limit),
    .count    (d_run)
  );

  // Requests seen during the reset cycle never win the RAM.
  always_comb begin
    i_req_v   = i_req & ~reset;
    d_req_v   = d_req & ~reset;
    i_gnt     = i_req_v & (~d_req_v | run_at_limit);
    d_gnt     = d_req_v & ~i_gnt;
    i_stall   = i_req & ~i_gnt;
    d_stall   = d_req & ~d_gnt;
    run_clear = i_gnt | ~i_req_v;
    run_inc   = d_gnt & i_req_v;
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_wdata = '0;
    if (i_gnt) begin
      mem_addr = MEM_AW'(word_addr(32'(i_addr), OFF_W));
      mem_re   = 1'b1;
    end else if (d_gnt) begin
      mem_addr  = MEM_AW'(word_addr(32'(d_addr), OFF_W));
      mem_we    = d_we;
      mem_re    = ~d_we;
      mem_wdata = d_wdata;
    end
  end

  // RAM data is routed straight through on the return cycle and kept in a hold register afterwards.
  always_comb begin
    i_rvalid   = (rd_owner_q == OWN_I) & ~reset;
    d_rvalid   = (rd_owner_q == OWN_D) & ~reset;
    i_rdata    = i_rvalid ? mem_rdata : i_hold_q;
    d_rdata    = d_rvalid ? mem_rdata : d_hold_q;
    i_hold_d   = i_rdata;
    d_hold_d   = d_rdata;
    rd_owner_d = OWN_NONE;
    if (i_gnt) begin
      rd_owner_d = OWN_I;
    end else if (d_gnt && !d_we) begin
      rd_owner_d = OWN_D;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_owner_q <= OWN_NONE;
      i_hold_q   <= '0;
      d_hold_q   <= '0;
    end else begin
      rd_owner_q <= rd_owner_d;
      i_hold_q   <= i_hold_d;
      d_hold_q   <= d_hold_d;
    end
  end

endmodule
